wb_gpio_bank: RTL

WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

---
 rtl/haui_gpio_pkg.sv | 25 ++
 rtl/wb_gpio_bank_if.sv | 19 +
 rtl/gpio_sync.sv | 16 +
 rtl/wb_gpio_bank.sv | 117 +++++++++++
 4 files changed

// File: rtl/haui_gpio_pkg.sv
// haui_gpio_pkg: register map, reset values and lane-merge helpers shared by the GPIO bank.
package haui_gpio_pkg;
  localparam int NUM_IO_MAX = 32;
  typedef enum logic [7:0] {
    REG_OUT      = 8'h00,
    REG_OEB      = 8'h04,
    REG_IN       = 8'h08,
    REG_IRQ_EN   = 8'h0C,
    REG_IRQ_EDGE = 8'h10,
    REG_IRQ_STAT = 8'h14
  } reg_off_e;
  localparam logic [NUM_IO_MAX-1:0] OUT_RST      = '0;
  localparam logic [NUM_IO_MAX-1:0] OEB_RST      = '1;
  localparam logic [NUM_IO_MAX-1:0] IRQ_EN_RST   = '0;
  localparam logic [NUM_IO_MAX-1:0] IRQ_EDGE_RST = '1;
  localparam logic [NUM_IO_MAX-1:0] IRQ_STAT_RST = '0;
  function automatic logic [NUM_IO_MAX-1:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
  function automatic logic [NUM_IO_MAX-1:0] lane_merge(input logic [NUM_IO_MAX-1:0] old,
                                                       input logic [31:0] dat,
                                                       input logic [3:0] sel);
    return (old & ~sel_mask(sel)) | (dat & sel_mask(sel));
  endfunction
endpackage

// File: rtl/wb_gpio_bank_if.sv
// wb_gpio_bank_if: Wishbone classic slave signal bundle for the GPIO bank.
interface wb_gpio_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: STAGES-deep multi-bit flop synchronizer for asynchronous pad inputs.
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [STAGES-1:0][WIDTH-1:0] r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= '0;
    else r_q <= {r_q[STAGES-2:0], i_d};
  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone GPIO bank with OUT/OEB registers, synchronized IN and optional edge IRQs.
// Define GPIO_BANK_IRQ_EN to build IRQ_EN/IRQ_EDGE/IRQ_STAT and a live irq_o.
module wb_gpio_bank
  import haui_gpio_pkg::*;
#(
  parameter int          NUM_IO      = 16,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  wb_gpio_bank_if.slave     wbs,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq_o
);
  logic [1:0]        r_rst_q;
  logic              w_rst_n;
  logic              w_hit, w_acc, w_wr;
  logic [7:0]        w_off;
  logic [31:0]       w_dat;
  logic [3:0]        w_sel;
  logic              r_ack;
  logic [31:0]       r_dat, w_rdata, w_rd_en, w_rd_edge, w_rd_stat;
  logic [NUM_IO-1:0] r_out, r_oeb, w_sync;

  function automatic logic [NUM_IO-1:0] wr_merge(input logic [NUM_IO-1:0] old,
                                                 input logic [31:0] dat,
                                                 input logic [3:0] sel);
    return NUM_IO'(lane_merge(NUM_IO_MAX'(old), dat, sel));
  endfunction

  // Reset asserts asynchronously but every other flop sees its release aligned to the clock.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) r_rst_q <= '0;
    else r_rst_q <= {r_rst_q[0], 1'b1};
  assign w_rst_n = r_rst_q[1];

  assign w_dat = wbs.wbs_dat_i;
  assign w_sel = wbs.wbs_sel_i;
  assign w_off = wbs.wbs_adr_i[7:0];
  assign w_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_acc = w_hit & ~r_ack;
  assign w_wr  = w_acc & wbs.wbs_we_i;

  gpio_sync #(.WIDTH(NUM_IO), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (w_rst_n),
    .i_d     (io_in),
    .o_q     (w_sync)
  );

  always_comb
    w_rdata = (w_off == REG_OUT)      ? 32'(r_out)  :
              (w_off == REG_OEB)      ? 32'(r_oeb)  :
              (w_off == REG_IN)       ? 32'(w_sync) :
              (w_off == REG_IRQ_EN)   ? w_rd_en     :
              (w_off == REG_IRQ_EDGE) ? w_rd_edge   :
              (w_off == REG_IRQ_STAT) ? w_rd_stat   : '0;

  always_ff @(posedge wb_clk_i or negedge w_rst_n)
    if (!w_rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_out <= NUM_IO'(OUT_RST);
      r_oeb <= NUM_IO'(OEB_RST);
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc & ~wbs.wbs_we_i) ? w_rdata : '0;
      if (w_wr && w_off == REG_OUT) r_out <= wr_merge(r_out, w_dat, w_sel);
      if (w_wr && w_off == REG_OEB) r_oeb <= wr_merge(r_oeb, w_dat, w_sel);
    end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign io_out = r_out;
  assign io_oeb = r_oeb;

`ifdef GPIO_BANK_IRQ_EN
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);
  logic [NUM_IO-1:0] r_irq_en, r_irq_edge, r_irq_stat, r_sync_d, w_edge, w_w1c;
  logic [2:0]        r_arm;
  logic              r_irq;

  // An edge counts when the pad changed and its new level matches the selected polarity.
  assign w_edge = (r_arm == ARM_DONE) ? (w_sync ^ r_sync_d) & ~(w_sync ^ r_irq_edge) : '0;
  assign w_w1c  = (w_wr && w_off == REG_IRQ_STAT) ? NUM_IO'(sel_mask(w_sel) & w_dat) : '0;

  always_ff @(posedge wb_clk_i or negedge w_rst_n)
    if (!w_rst_n) begin
      r_irq_en   <= NUM_IO'(IRQ_EN_RST);
      r_irq_edge <= NUM_IO'(IRQ_EDGE_RST);
      r_irq_stat <= NUM_IO'(IRQ_STAT_RST);
      r_sync_d   <= '0;
      r_arm      <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && w_off == REG_IRQ_EN)   r_irq_en   <= wr_merge(r_irq_en, w_dat, w_sel);
      if (w_wr && w_off == REG_IRQ_EDGE) r_irq_edge <= wr_merge(r_irq_edge, w_dat, w_sel);
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_edge;
      r_sync_d   <= w_sync;
      r_arm      <= (r_arm == ARM_DONE) ? r_arm : r_arm + 3'd1;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end

  assign w_rd_en   = 32'(r_irq_en);
  assign w_rd_edge = 32'(r_irq_edge);
  assign w_rd_stat = 32'(r_irq_stat);
  assign irq_o     = r_irq;
`else
  assign w_rd_en   = '0;
  assign w_rd_edge = '0;
  assign w_rd_stat = '0;
  assign irq_o     = 1'b0;
`endif
endmodule
